imem_boot_arbiter: RTL
======================

Name: imem_boot_arbiter

Overview:
Owns the single port of the instruction ROM/RAM and arbitrates it between the instruction fetch unit (normal run) and a UART program loader (programming mode). On a programming request it holds the CPU in reset and assembles incoming bytes into 32-bit little-endian words. It writes those words to consecutive word addresses from 0, then releases the CPU so fetch restarts at PC 0. It sits between the fetch unit's word address, the UART receiver, and the instruction memory port mux.

Parameters:
ADDR_WIDTH, 14, instruction memory word-address width (depth 2^ADDR_WIDTH words)
ISA_WIDTH, 32, instruction word width (fixed at 4 bytes)
IDLE_TIMEOUT, 50000000, cycles with no rx byte after the first byte before the load auto-finishes (>=2)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  reset, synchronous, active-high
prog_req  input  1  one-cycle pulse requesting programming mode (debounced button)
rx_valid  input  1  one-cycle strobe: rx_byte is valid
rx_byte  input  8  received UART byte
rx_done  input  1  one-cycle pulse: host finished sending
fetch_addr  input  ADDR_WIDTH  word address from fetch unit (PC[ADDR_WIDTH+1:2])
mem_addr  output  ADDR_WIDTH  word address to instruction memory
mem_we  output  1  write enable to instruction memory
mem_din  output  ISA_WIDTH  write data to instruction memory
cpu_hold  output  1  forces the CPU/fetch reset while high
loader_active  output  1  high while the loader owns the memory port
words_loaded  output  ADDR_WIDTH+1  count of words written in the current/last load
load_err  output  1  sticky: partial word discarded or memory overflow in last load

Behaviour:
- States: RUN, ENTER, LOAD, WRITE, FINISH.
- Reset (any state, including mid-load): state=RUN; mem_we=0, mem_din=0, cpu_hold=0, loader_active=0, words_loaded=0, load_err=0; byte index, word address, and timeout counter cleared. Memory contents are not touched.
- RUN: mem_addr = fetch_addr (combinational); mem_we=0. prog_req -> ENTER. rx_valid and rx_done are ignored.
- ENTER (1 cycle): cpu_hold=1, loader_active=1. Clears byte index, word address, words_loaded, load_err, timeout counter, and the first-byte flag. -> LOAD.
- LOAD: cpu_hold=1, loader_active=1, mem_addr = word address, mem_we=0.
  - On rx_valid: byte goes to asm[8*idx +: 8]; idx increments; timeout counter clears; first-byte flag sets. When idx was 3: -> WRITE.
  - rx_done, or timeout expiry: -> FINISH. If idx != 0, the partial word is discarded and load_err=1.
  - Timeout: counts only when the first-byte flag is set. It expires when the counter reaches IDLE_TIMEOUT-1 with no rx_valid.
  - rx_done and rx_valid in the same cycle: the byte is captured first, then done is evaluated using the updated idx.
  - prog_req is ignored.
- WRITE (1 cycle): mem_we=1, mem_addr = word address, mem_din = assembled word. words_loaded increments.
  - If the word address was 2^ADDR_WIDTH-1: load_err=1, -> FINISH. There is no wrap-around.
  - Otherwise the word address increments, -> LOAD.
  - rx_valid arriving in WRITE is captured as byte 0 of the next word; no byte is lost.
  - rx_done in WRITE -> FINISH after the write.
- FINISH (1 cycle): cpu_hold=1, loader_active=1, mem_we=0. -> RUN.
  - cpu_hold drops on the first RUN cycle, so the CPU leaves reset with PC=0.
  - words_loaded and load_err hold until the next ENTER or reset.
- Latency: the 4th byte of a word is written on the cycle after its rx_valid.
- Minimum byte spacing is 1 cycle; back-to-back rx_valid is supported.

Test Plan:
- Reset, then fetch_addr=0x0012 -> mem_addr=0x0012, mem_we=0, cpu_hold=0, loader_active=0.
- Load 2 words: prog_req; bytes 78 56 34 12 EF BE AD DE; rx_done. Expected:
  - cpu_hold=1 from the cycle after prog_req.
  - Writes 0x12345678 at addr 0 and 0xDEADBEEF at addr 1, each mem_we pulse one cycle.
  - words_loaded=2, load_err=0; cpu_hold=0 two cycles after rx_done.
- Back-to-back bytes: 8 bytes on consecutive cycles (rx_valid high 8 cycles) -> both words written correctly, including the byte landing in a WRITE cycle.
- Partial and timeout (IDLE_TIMEOUT=16): send 5 bytes, then silence. Expected:
  - FINISH entered 16 cycles after the last byte.
  - One word written; words_loaded=1, load_err=1.
- Overflow (ADDR_WIDTH=2): send 5 full words -> words 0..3 written, words_loaded=4, load_err=1, 5th word never written, return to RUN.
- Reset mid-load after 6 bytes -> state RUN, cpu_hold=0, words_loaded=0, no further mem_we; a subsequent prog_req restarts at address 0.

Source files
------------

// File: rtl/imem_boot_arbiter_if.sv
// UART receive stream into the instruction-memory boot arbiter.
// The receiver is the master and drives the stream; the arbiter is the slave.
interface imem_boot_arbiter_if;
    logic       rx_valid;  // one-cycle strobe: rx_byte is valid
    logic [7:0] rx_byte;   // received byte
    logic       rx_done;   // one-cycle pulse: host finished sending

    modport master (output rx_valid, rx_byte, rx_done);
    modport slave  (input  rx_valid, rx_byte, rx_done);
endinterface

// File: rtl/imem_boot_arbiter.sv
// Instruction-memory port arbiter.
// In normal run the fetch unit owns the port. A programming request holds the
// CPU in reset, packs UART bytes into little-endian words, and writes them to
// consecutive word addresses starting at 0. It then releases the CPU so that
// fetch restarts at PC 0.
module imem_boot_arbiter #(
    parameter int ADDR_WIDTH   = 14,
    parameter int ISA_WIDTH    = 32,
    parameter int IDLE_TIMEOUT = 50000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  prog_req,
    imem_boot_arbiter_if.slave    rx,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [ISA_WIDTH-1:0]  mem_din,
    output logic                  cpu_hold,
    output logic                  loader_active,
    output logic [ADDR_WIDTH:0]   words_loaded,
    output logic                  load_err
);

    typedef enum logic [2:0] {RUN, ENTER, LOAD, WRITE, FINISH} state_e;

    // Idle counter expires on the cycle it would reach IDLE_TIMEOUT-1.
    localparam int                TMO_W    = $clog2(IDLE_TIMEOUT);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(IDLE_TIMEOUT - 2);

    state_e                state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ISA_WIDTH-1:0]  asm_q, asm_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  first_q, first_d;
    logic                  pend_q, pend_d;     // rx_done seen while completing a word
    logic [ADDR_WIDTH:0]   words_q, words_d;
    logic                  err_q, err_d;
    logic [ISA_WIDTH-1:0]  din_q, din_d;
    logic                  we_q, hold_q;
    logic                  timeout_hit;

    // Next-state and datapath update for the loader FSM.
    always_comb begin
        // NOTE: every variable gets a default first, so no branch can infer a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        asm_d       = asm_q;
        tmo_d       = tmo_q;
        first_d     = first_q;
        pend_d      = pend_q;
        words_d     = words_q;
        err_d       = err_q;
        din_d       = din_q;
        timeout_hit = 1'b0;

        // Byte capture and idle timing are shared by LOAD and WRITE, so a
        // byte arriving during a write cycle becomes byte 0 of the next word.
        if (state_q == LOAD || state_q == WRITE) begin
            if (rx.rx_valid) begin
                asm_d[{idx_q, 3'b000} +: 8] = rx.rx_byte;
                idx_d   = idx_q + 2'd1;
                tmo_d   = '0;
                first_d = 1'b1;
            end else if (first_q) begin
                tmo_d       = tmo_q + 1'b1;
                timeout_hit = (tmo_q == TMO_LAST);
            end
        end

        case (state_q)
            RUN: begin
                if (prog_req) state_d = ENTER;
            end
            ENTER: begin
                idx_d   = '0;
                addr_d  = '0;
                words_d = '0;
                err_d   = 1'b0;
                tmo_d   = '0;
                first_d = 1'b0;
                pend_d  = 1'b0;
                state_d = LOAD;
            end
            LOAD: begin
                if (rx.rx_valid && idx_q == 2'd3) begin
                    din_d   = asm_d;
                    pend_d  = rx.rx_done;
                    state_d = WRITE;
                end else if (rx.rx_done || timeout_hit) begin
                    if (idx_d != 2'd0) err_d = 1'b1;
                    state_d = FINISH;
                end
            end
            WRITE: begin
                words_d = words_q + 1'b1;
                pend_d  = 1'b0;
                if (addr_q == '1) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    addr_d = addr_q + 1'b1;
                    if (rx.rx_done || pend_q || timeout_hit) begin
                        if (idx_d != 2'd0) err_d = 1'b1;
                        state_d = FINISH;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            FINISH: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State and registered outputs; the outputs follow the next state.
    always_ff @(posedge clock) begin
        // NOTE: the word assembly buffer is pure datapath and is always written
        // before it is read, so it has no reset.
        asm_q <= asm_d;
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state_q <= RUN;
            idx_q   <= '0;
            addr_q  <= '0;
            tmo_q   <= '0;
            first_q <= 1'b0;
            pend_q  <= 1'b0;
            words_q <= '0;
            err_q   <= 1'b0;
            din_q   <= '0;
            we_q    <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            tmo_q   <= tmo_d;
            first_q <= first_d;
            pend_q  <= pend_d;
            words_q <= words_d;
            err_q   <= err_d;
            din_q   <= din_d;
            we_q    <= (state_d == WRITE);
            hold_q  <= (state_d != RUN);
        end
    end

    // The fetch unit drives the address directly while the CPU runs.
    always_comb begin
        mem_addr = (state_q == RUN) ? fetch_addr : addr_q;
    end

    assign mem_we        = we_q;
    assign mem_din       = din_q;
    assign cpu_hold      = hold_q;
    assign loader_active = hold_q;
    assign words_loaded  = words_q;
    assign load_err      = err_q;

endmodule
